cxl_axi_miss_master: RTL and testbench
======================================

Name: cxl_axi_miss_master

Overview:
- AXI master that sits directly upstream of the CXL memory slave model.
- Converts single-line fill (read) and evict (write) requests from the DRAM-cache controller into AXI AR/R and AW/W/B transactions on 64 B lines.
- Returns fill data or a write acknowledge to the controller.
- One transaction outstanding at a time; requests are processed in order.

Parameters:
- ADDR_W, 64: byte address width.
- DATA_W, 512: line data width (64 B).
- TAG_W, 64: extra upper bits on the slave R data (tag field); ignored by this block.
- ID_W, 16: AXI ID width.
- AXI_ID, 1: constant ID driven on arid/awid/wid.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  controller request valid
- req_ready  out  1  block can accept a request
- req_we  in  1  1=evict (write), 0=fill (read)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  evict data
- rsp_valid  out  1  response valid
- rsp_ready  in  1  controller takes response
- rsp_we  out  1  echo of req_we for this response
- rsp_rdata  out  DATA_W  fill data (0 for writes)
- arid_o  out  ID_W  AR ID
- araddr_o  out  ADDR_W  AR address
- arvalid_o  out  1  AR valid
- arready_i  in  1  AR ready
- rid_i  in  ID_W  R ID
- rdata_i  in  TAG_W+DATA_W  R data
- rvalid_i  in  1  R valid
- rready_o  out  1  R ready
- awid_o  out  ID_W  AW ID
- awaddr_o  out  ADDR_W  AW address
- awvalid_o  out  1  AW valid
- awready_i  in  1  AW ready
- wid_o  out  ID_W  W ID
- wdata_o  out  DATA_W  W data
- wvalid_o  out  1  W valid
- wready_i  in  1  W ready
- bid_i  in  ID_W  B ID
- bvalid_i  in  1  B valid
- bready_o  out  1  B ready

Behaviour:
- **States:** IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RSP.
- **Reset:** state=IDLE. All valid outputs (arvalid, awvalid, wvalid, rsp_valid) are 0; rready, bready are 0. Address, data and rsp_rdata registers are 0. req_ready is 1 after reset (req_ready = state==IDLE).
- **IDLE:**
  - On req_valid && req_ready, latch req_we and req_addr with bits [5:0] forced to 0.
  - Latch req_wdata for writes.
  - Next state is RD_ADDR if req_we=0, else WR_REQ.
  - arvalid/awvalid are first high the cycle after acceptance.
- **RD_ADDR:**
  - arvalid_o=1 with araddr_o stable.
  - On arready_i, go to RD_DATA.
  - arvalid must drop the cycle after the handshake.
- **RD_DATA:**
  - rready_o=1.
  - On rvalid_i, capture rdata_i[DATA_W-1:0] into rsp_rdata; upper TAG_W bits are discarded. Go to RSP.
  - rid_i is not checked.
- **WR_REQ:**
  - awvalid_o and wvalid_o both assert on entry.
  - Each drops independently after its own handshake; a per-channel done flag is held.
  - AW and W may complete in the same cycle or in either order.
  - When both are done, go to WR_RESP.
  - wdata/awaddr are stable while their valid is high.
- **WR_RESP:** bready_o=1. On bvalid_i, go to RSP; rsp_rdata=0.
- **RSP:**
  - rsp_valid=1, holding rsp_we and rsp_rdata stable until rsp_ready.
  - On rsp_ready, go to IDLE.
  - Earliest re-accept is the cycle after rsp_ready.
- **Latency:** with zero-wait slave ready/valid, a read takes request cycle 0, AR hs cycle 1, R hs cycle 2, rsp_valid cycle 3.
- **Single outstanding transaction:** req_ready=0 in all states except IDLE; requests presented then are not accepted and must be held by the controller.
- **Reset mid-operation:** returns to IDLE next edge and drops all valids; an in-flight slave transaction is abandoned. The bench resets the slave with the block.
- Address wrap is not applicable (no bursts; one beat per transaction).

Optional Feature:
- **Macro:** CXL_MISS_MASTER_STATS_EN.
- **Enabled:** adds outputs stat_rd_cnt, stat_wr_cnt, stat_rd_lat (each 32 b).
  - rd_cnt increments on each R handshake.
  - wr_cnt increments on each B handshake.
  - rd_lat accumulates cycles from arvalid first high through the R handshake, inclusive.
  - All three saturate at 2^32-1 and reset to 0.
- **Disabled:** no ports and no counter logic; behaviour is otherwise identical.

Test Plan:
- **Zero-wait read:** fill addr 0x1040 -> araddr_o=0x1040, arid_o=1. Slave returns rdata low 512 b = {16{32'hDEADBEEF}} -> rsp_valid at cycle 3, rsp_we=0, rsp_rdata matches.
- **Unaligned address:** evict addr 0x2007, wdata=512'hA5..A5 -> awaddr_o=0x2000, wdata_o=A5..A5. After bvalid, rsp_valid=1, rsp_we=1, rsp_rdata=0.
- **AW/W ordering:** wready_i high 3 cycles before awready_i -> wvalid drops after its handshake, awvalid held until its own. Exactly one B wait, one response.
- **Backpressure:** rsp_ready low 5 cycles -> rsp_valid and data stable. A second req_valid during this time is not accepted (req_ready=0); it is accepted the cycle after rsp_ready.
- **Reset mid-operation:** rst_n low for 1 cycle during RD_DATA -> all valids 0, req_ready=1 next cycle. A new fill to 0x40 then completes normally.
- **Stats (macro on):** 3 reads with slave R delay 4 cycles plus 2 writes -> stat_rd_cnt=3, stat_wr_cnt=2, stat_rd_lat equals the bench-computed cycle sum.

Source files
------------

// File: rtl/cxl_axi_miss_master.sv
// rtl/cxl_axi_miss_master.sv - single-outstanding AXI master turning line fill/evict requests into AR/R and AW/W/B transactions
// Optional read/write counters and read-latency accumulator under `CXL_MISS_MASTER_STATS_EN.
module cxl_axi_miss_master #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 512,
    parameter int TAG_W  = 64,
    parameter int ID_W   = 16,
    parameter int AXI_ID = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [DATA_W-1:0]       req_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_we,
    output logic [DATA_W-1:0]       rsp_rdata,
    output logic [ID_W-1:0]         arid_o,
    output logic [ADDR_W-1:0]       araddr_o,
    output logic                    arvalid_o,
    input  logic                    arready_i,
    input  logic [ID_W-1:0]         rid_i,
    input  logic [TAG_W+DATA_W-1:0] rdata_i,
    input  logic                    rvalid_i,
    output logic                    rready_o,
    output logic [ID_W-1:0]         awid_o,
    output logic [ADDR_W-1:0]       awaddr_o,
    output logic                    awvalid_o,
    input  logic                    awready_i,
    output logic [ID_W-1:0]         wid_o,
    output logic [DATA_W-1:0]       wdata_o,
    output logic                    wvalid_o,
    input  logic                    wready_i,
    input  logic [ID_W-1:0]         bid_i,
    input  logic                    bvalid_i,
    output logic                    bready_o
`ifdef CXL_MISS_MASTER_STATS_EN
    ,
    output logic [31:0]             stat_rd_cnt,
    output logic [31:0]             stat_wr_cnt,
    output logic [31:0]             stat_rd_lat
`endif
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        RSP     = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;

    // IDs are never checked and the tag field of R data is dropped.
    logic unused_ok;
    assign unused_ok = ^{rid_i, bid_i, rdata_i[TAG_W+DATA_W-1:DATA_W]};

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d      = req_we;
                    addr_d    = {req_addr[ADDR_W-1:6], 6'b0};
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (req_we) begin
                        wdata_d = req_wdata;
                        state_d = WR_REQ;
                    end else begin
                        state_d = RD_ADDR;
                    end
                end
            end
            RD_ADDR: begin
                if (arready_i) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (rvalid_i) begin
                    rdata_d = rdata_i[DATA_W-1:0];
                    state_d = RSP;
                end
            end
            WR_REQ: begin
                // AW and W complete independently; leave once both have.
                if (!aw_done_q && awready_i) aw_done_d = 1'b1;
                if (!w_done_q && wready_i)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d)   state_d   = WR_RESP;
            end
            WR_RESP: begin
                if (bvalid_i) begin
                    rdata_d = '0;
                    state_d = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RSP);
    assign rsp_we    = we_q;
    assign rsp_rdata = rdata_q;

    assign arid_o    = ID_W'(AXI_ID);
    assign araddr_o  = addr_q;
    assign arvalid_o = (state_q == RD_ADDR);
    assign rready_o  = (state_q == RD_DATA);

    assign awid_o    = ID_W'(AXI_ID);
    assign awaddr_o  = addr_q;
    assign awvalid_o = (state_q == WR_REQ) && !aw_done_q;
    assign wid_o     = ID_W'(AXI_ID);
    assign wdata_o   = wdata_q;
    assign wvalid_o  = (state_q == WR_REQ) && !w_done_q;
    assign bready_o  = (state_q == WR_RESP);

`ifdef CXL_MISS_MASTER_STATS_EN
    logic [31:0] rd_cnt_q, rd_cnt_d;
    logic [31:0] wr_cnt_q, wr_cnt_d;
    logic [31:0] rd_lat_q, rd_lat_d;

    // Latency counts every cycle spent in AR or R, i.e. arvalid first high through the R handshake.
    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        rd_lat_d = rd_lat_q;
        if (state_q == RD_DATA && rvalid_i && rd_cnt_q != 32'hFFFF_FFFF)
            rd_cnt_d = rd_cnt_q + 32'd1;
        if (state_q == WR_RESP && bvalid_i && wr_cnt_q != 32'hFFFF_FFFF)
            wr_cnt_d = wr_cnt_q + 32'd1;
        if ((state_q == RD_ADDR || state_q == RD_DATA) && rd_lat_q != 32'hFFFF_FFFF)
            rd_lat_d = rd_lat_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            rd_lat_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            rd_lat_q <= rd_lat_d;
        end
    end

    assign stat_rd_cnt = rd_cnt_q;
    assign stat_wr_cnt = wr_cnt_q;
    assign stat_rd_lat = rd_lat_q;
`endif

endmodule

// File: tb/tb_cxl_axi_miss_master.sv
// tb/tb_cxl_axi_miss_master.sv - randomized bench for cxl_axi_miss_master with a cycle-level slave and transaction model
module tb_cxl_axi_miss_master;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid, req_ready, req_we;
    logic [63:0]  req_addr;
    logic [511:0] req_wdata;
    logic         rsp_valid, rsp_ready, rsp_we;
    logic [511:0] rsp_rdata;
    logic [15:0]  arid_o, awid_o, wid_o;
    logic [63:0]  araddr_o, awaddr_o;
    logic         arvalid_o, arready_i;
    logic [15:0]  rid_i, bid_i;
    logic [575:0] rdata_i;
    logic         rvalid_i, rready_o;
    logic         awvalid_o, awready_i;
    logic [511:0] wdata_o;
    logic         wvalid_o, wready_i;
    logic         bvalid_i, bready_o;
`ifdef CXL_MISS_MASTER_STATS_EN
    logic [31:0]  stat_rd_cnt, stat_wr_cnt, stat_rd_lat;
`endif

    cxl_axi_miss_master dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata),
        .arid_o(arid_o), .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rid_i(rid_i), .rdata_i(rdata_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
        .awid_o(awid_o), .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wid_o(wid_o), .wdata_o(wdata_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
        .bid_i(bid_i), .bvalid_i(bvalid_i), .bready_o(bready_o)
`ifdef CXL_MISS_MASTER_STATS_EN
        , .stat_rd_cnt(stat_rd_cnt), .stat_wr_cnt(stat_wr_cnt), .stat_rd_lat(stat_rd_lat)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;
    int m_rd_cnt = 0;
    int m_wr_cnt = 0;
    int m_rd_lat = 0;

    logic         nxt_we;
    logic [63:0]  nxt_addr;
    logic [511:0] nxt_wd;

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic idle_inputs();
        req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0;
        rsp_ready = 0; arready_i = 0; rvalid_i = 0; rdata_i = '0; rid_i = 16'h0;
        awready_i = 0; wready_i = 0; bvalid_i = 0; bid_i = 16'h0;
    endtask

    // One transaction: starts and ends on a negedge. Slave delays count cycles the
    // corresponding master valid/ready has been seen before the slave answers.
    task automatic do_txn(input bit we, input logic [63:0] addr, input logic [511:0] wd,
                          input logic [511:0] rd, input int ar_d, input int r_d,
                          input int aw_d, input int w_d, input int b_d, input int rs_d,
                          input bit push_next);
        int ar_n = 0, r_n = 0, aw_n = 0, w_n = 0, b_n = 0, rs_n = 0;
        int ar_hs = 0, r_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0;
        int t_acc, t_rsp = -1, g = 0, exp_lat;
        bit done = 0, err_busy = 0, err_ch = 0, err_stab = 0;
        logic [63:0]  ea   = {addr[63:6], 6'b0};
        logic [511:0] erd  = we ? 512'd0 : rd;
        logic [63:0]  tagv = {$urandom, $urandom};
        req_valid = 1; req_we = we; req_addr = addr; req_wdata = wd;
        while (!req_ready && g < 50) begin @(negedge clk); g++; end
        check_eq("accept", req_ready, 1'b1);
        t_acc = cyc;
        @(negedge clk);
        req_valid = 0;
        g = 0;
        while (!done && g < 300) begin
            if (req_ready) err_busy = 1;
            if (arvalid_o && (we || ar_hs > 0 || araddr_o !== ea || arid_o !== 16'd1)) err_ch = 1;
            if (awvalid_o && (!we || aw_hs > 0 || awaddr_o !== ea || awid_o !== 16'd1)) err_ch = 1;
            if (wvalid_o && (!we || w_hs > 0 || wdata_o !== wd)) err_ch = 1;
            if (rready_o && (we || ar_hs == 0)) err_ch = 1;
            if (bready_o && (aw_hs == 0 || w_hs == 0)) err_ch = 1;
            arready_i = arvalid_o && (ar_n >= ar_d);
            rvalid_i  = rready_o && (r_n >= r_d);
            rdata_i   = {tagv, rd};
            rid_i     = 16'($urandom);
            awready_i = awvalid_o && (aw_n >= aw_d);
            wready_i  = wvalid_o && (w_n >= w_d);
            bvalid_i  = bready_o && (b_n >= b_d);
            bid_i     = 16'($urandom);
            rsp_ready = rsp_valid && (rs_n >= rs_d);
            if (arvalid_o) ar_n++;
            if (rready_o)  r_n++;
            if (awvalid_o) aw_n++;
            if (wvalid_o)  w_n++;
            if (bready_o)  b_n++;
            if (arvalid_o && arready_i) ar_hs++;
            if (rready_o && rvalid_i)   r_hs++;
            if (awvalid_o && awready_i) aw_hs++;
            if (wvalid_o && wready_i)   w_hs++;
            if (bready_o && bvalid_i)   b_hs++;
            if (rsp_valid) begin
                if (t_rsp < 0) t_rsp = cyc;
                if (rsp_we !== we || rsp_rdata !== erd) err_stab = 1;
                rs_n++;
                if (push_next && !rsp_ready) begin
                    req_valid = 1; req_we = nxt_we; req_addr = nxt_addr; req_wdata = nxt_wd;
                end
                if (rsp_ready) done = 1;
            end
            @(negedge clk);
            g++;
        end
        arready_i = 0; rvalid_i = 0; awready_i = 0; wready_i = 0; bvalid_i = 0; rsp_ready = 0;
        check_eq("done", done, 1'b1);
        check_eq("busy_req_ready", err_busy, 1'b0);
        check_eq("channel", err_ch, 1'b0);
        check_eq("rsp_stable", err_stab, 1'b0);
        check_eq("ar_hs", ar_hs, we ? 0 : 1);
        check_eq("r_hs", r_hs, we ? 0 : 1);
        check_eq("aw_hs", aw_hs, we ? 1 : 0);
        check_eq("w_hs", w_hs, we ? 1 : 0);
        check_eq("b_hs", b_hs, we ? 1 : 0);
        exp_lat = we ? (3 + ((aw_d > w_d) ? aw_d : w_d) + b_d) : (3 + ar_d + r_d);
        check_eq("rsp_latency", t_rsp - t_acc, exp_lat);
        check_eq("reaccept", req_ready, 1'b1);
        check_eq("rsp_drop", rsp_valid, 1'b0);
        if (we) m_wr_cnt++;
        else begin
            m_rd_cnt++;
            m_rd_lat += ar_d + r_d + 2;
        end
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        repeat (3) @(negedge clk);
        check_eq("rst_req_ready", req_ready, 1'b1);
        check_eq("rst_valids", {arvalid_o, awvalid_o, wvalid_o, rsp_valid, rready_o, bready_o}, 6'd0);
        check_eq("rst_rdata", rsp_rdata, 512'd0);
        check_eq("rst_addr", araddr_o, 64'd0);
        rst_n = 1;
        @(negedge clk);

        // Zero-wait fill
        do_txn(0, 64'h1040, '0, {16{32'hDEADBEEF}}, 0, 0, 0, 0, 0, 0, 0);
        // Unaligned evict
        do_txn(1, 64'h2007, {64{8'hA5}}, rnd512(), 0, 0, 0, 0, 0, 0, 0);
        // W completes three cycles ahead of AW, then the reverse
        do_txn(1, 64'h3000, rnd512(), rnd512(), 0, 0, 3, 0, 1, 0, 0);
        do_txn(1, 64'h3040, rnd512(), rnd512(), 0, 0, 0, 2, 0, 0, 0);
        // Response backpressure with a held second request
        nxt_we = 0; nxt_addr = 64'h5080; nxt_wd = '0;
        do_txn(0, 64'h4000, '0, rnd512(), 1, 2, 0, 0, 0, 5, 1);
        do_txn(nxt_we, nxt_addr, nxt_wd, rnd512(), 0, 0, 0, 0, 0, 0, 0);

        // Reset during RD_DATA
        req_valid = 1; req_we = 0; req_addr = 64'h80;
        @(negedge clk);
        req_valid = 0;
        check_eq("mid_arvalid", arvalid_o, 1'b1);
        arready_i = 1;
        @(negedge clk);
        arready_i = 0;
        check_eq("mid_rready", rready_o, 1'b1);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        check_eq("mid_valids", {arvalid_o, awvalid_o, wvalid_o, rsp_valid, rready_o, bready_o}, 6'd0);
        check_eq("mid_req_ready", req_ready, 1'b1);
        m_rd_cnt = 0; m_wr_cnt = 0; m_rd_lat = 0;
        do_txn(0, 64'h40, '0, rnd512(), 0, 0, 0, 0, 0, 0, 0);

        // Randomized mix
        for (int i = 0; i < 40; i++) begin
            do_txn(1'($urandom_range(0, 1)), {$urandom, $urandom}, rnd512(), rnd512(),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 0);
        end

`ifdef CXL_MISS_MASTER_STATS_EN
        check_eq("stat_rd_cnt_mix", stat_rd_cnt, m_rd_cnt);
        check_eq("stat_wr_cnt_mix", stat_wr_cnt, m_wr_cnt);
        check_eq("stat_rd_lat_mix", stat_rd_lat, m_rd_lat);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        m_rd_cnt = 0; m_wr_cnt = 0; m_rd_lat = 0;
        check_eq("stat_rst", {stat_rd_cnt, stat_wr_cnt, stat_rd_lat}, 96'd0);
        for (int i = 0; i < 3; i++)
            do_txn(0, 64'h9000 + 64'(i * 64), '0, rnd512(), $urandom_range(0, 2), 4, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++)
            do_txn(1, 64'hA000 + 64'(i * 64), rnd512(), rnd512(), 0, 0, 1, 2, 1, 0, 0);
        check_eq("stat_rd_cnt", stat_rd_cnt, m_rd_cnt);
        check_eq("stat_wr_cnt", stat_wr_cnt, m_wr_cnt);
        check_eq("stat_rd_lat", stat_rd_lat, m_rd_lat);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
